// File: rtl/mem_if_pkg.sv
// Shared opcodes, RAM width codes, response codes and FSM states for the
// MOV/MOC memory access initiator.
package mem_if_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [5:0] RAM_BYTE = 6'b100000;
  localparam logic [5:0] RAM_HALF = 6'b100001;
  localparam logic [5:0] RAM_WORD = 6'b100011;

  localparam logic [2:0] ERR_OK       = 3'b000;
  localparam logic [2:0] ERR_ILLEGAL  = 3'b001;
  localparam logic [2:0] ERR_MISALIGN = 3'b010;
  localparam logic [2:0] ERR_RANGE    = 3'b011;
  localparam logic [2:0] ERR_TIMEOUT  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Loads collapse onto the RAM width codes; stores already carry one.
  function automatic logic [5:0] ram_op(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU:       return RAM_BYTE;
      OP_LH, OP_LHU:       return RAM_HALF;
      OP_LW:               return RAM_WORD;
      OP_SB, OP_SH, OP_SW: return op;
      default:             return 6'b000000;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lsb);
    case (op)
      OP_LH, OP_LHU, OP_SH: return lsb[0];
      OP_LW, OP_SW:         return |lsb;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Combinational load-data extender: sign-extends lb/lh, passes everything else.
module mem_load_ext
  import mem_if_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] rdata,
  output logic [31:0] ext
);

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    ext = rdata;
    case (op)
      OP_LB:   ext = {{24{rdata[7]}}, rdata[7:0]};
      OP_LH:   ext = {{16{rdata[15]}}, rdata[15:0]};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_initiator.sv
// Single-outstanding-request bus master: validates a load/store, runs the
// MOV/MOC handshake with the RAM and returns extended data plus a status code.
module mem_access_initiator
  import mem_if_pkg::*;
#(
  parameter int MEM_BYTES = 512,
  parameter int TIMEOUT   = 15
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [2:0]  rsp_err,
  output logic        MOV,
  output logic        RW,
  output logic [31:0] Address,
  output logic [31:0] mem_wdata,
  output logic [5:0]  OP,
  input  logic [31:0] mem_rdata,
  input  logic        MOC
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [5:0]  mem_op_q, mem_op_d;
  logic        rw_q, rw_d;
  logic        mov_q, mov_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [2:0]  rsp_err_q, rsp_err_d;

  logic [31:0]      ext_rdata;
  logic [CNT_W-1:0] cnt_inc;

  mem_load_ext u_load_ext (
    .op    (op_q),
    .rdata (mem_rdata),
    .ext   (ext_rdata)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_op_d    = mem_op_q;
    rw_d        = rw_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = ERR_OK;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d     = req_op;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          mem_op_d = ram_op(req_op);
          rw_d     = ~is_store(req_op);
          if (!is_legal(req_op)) begin
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_ILLEGAL;
          end else if (is_misaligned(req_op, req_addr[1:0])) begin
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_MISALIGN;
          end else if (req_addr >= 32'(MEM_BYTES)) begin
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_RANGE;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      // MOC may still be high from the previous access, so it is not looked at here.
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (MOC) begin
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = is_load(op_q) ? ext_rdata : 32'h0;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          state_d     = ST_DONE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    mov_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!Clr) begin
      state_q     <= ST_IDLE;
      op_q        <= 6'b000000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      mem_op_q    <= 6'b000000;
      rw_q        <= 1'b1;
      mov_q       <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= ERR_OK;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_op_q    <= mem_op_d;
      rw_q        <= rw_d;
      mov_q       <= mov_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign MOV       = mov_q;
  assign RW        = rw_q;
  assign Address   = addr_q;
  assign mem_wdata = wdata_q;
  assign OP        = mem_op_q;

endmodule

// File: tb/tb_mem_access_initiator.sv
// Scoreboard bench for mem_access_initiator with a little-endian byte RAM model
// that answers MOV with MOC after a programmable delay.
module tb_mem_access_initiator;
  import mem_if_pkg::*;

  localparam int MEM_BYTES = 512;
  localparam int TIMEOUT   = 15;

  logic        Clk = 1'b0;
  logic        Clr;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_err;
  logic        MOV;
  logic        RW;
  logic [31:0] Address;
  logic [31:0] mem_wdata;
  logic [5:0]  OP;
  logic [31:0] mem_rdata;
  logic        MOC;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  logic [7:0] ram [MEM_BYTES];
  int moc_delay  = 1;
  bit moc_stale  = 1'b0;
  int mov_cycles = 0;

  always #5 Clk = ~Clk;

  mem_access_initiator #(.MEM_BYTES(MEM_BYTES), .TIMEOUT(TIMEOUT)) dut (
    .Clk       (Clk),
    .Clr       (Clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .MOV       (MOV),
    .RW        (RW),
    .Address   (Address),
    .mem_wdata (mem_wdata),
    .OP        (OP),
    .mem_rdata (mem_rdata),
    .MOC       (MOC)
  );

  function automatic logic [31:0] ram_read(input logic [31:0] a, input logic [5:0] op);
    int i;
    i = int'(a[8:0]);
    case (op)
      RAM_BYTE: return {24'h0, ram[i]};
      RAM_HALF: return {16'h0, ram[i+1], ram[i]};
      default:  return {ram[i+3], ram[i+2], ram[i+1], ram[i]};
    endcase
  endfunction

  // RAM model: MOC rises moc_delay cycles after the ISSUE cycle; writes land then.
  always @(posedge Clk) begin
    #1;
    if (!MOV) begin
      mov_cycles = 0;
      mem_rdata  = 32'h0;
      if (!moc_stale) MOC = 1'b0;
    end else begin
      int i;
      mov_cycles = mov_cycles + 1;
      i = int'(Address[8:0]);
      if (RW) mem_rdata = ram_read(Address, OP);
      if (mov_cycles == moc_delay + 1) begin
        MOC = 1'b1;
        if (!RW) begin
          case (OP)
            OP_SB: ram[i] = mem_wdata[7:0];
            OP_SH: begin ram[i] = mem_wdata[7:0]; ram[i+1] = mem_wdata[15:8]; end
            default: begin
              ram[i]   = mem_wdata[7:0];
              ram[i+1] = mem_wdata[15:8];
              ram[i+2] = mem_wdata[23:16];
              ram[i+3] = mem_wdata[31:24];
            end
          endcase
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input string name, input logic [5:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic [2:0] exp_err, input int exp_lat);
    exp_t e;
    exp_t got;
    int   n;
    bit   done;
    bit   mov_seen;
    bit   bus_bad;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_lat;
    sb.push_back(e);

    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s ready: req_ready=%b want 1", name, req_ready);
    end

    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0; req_op = 6'b000000; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hA5A5_A5A5;

    n = 1; done = 1'b0; mov_seen = 1'b0; bus_bad = 1'b0;
    while (n <= 40 && !done) begin
      if (MOV) begin
        mov_seen = 1'b1;
        if (Address !== addr || mem_wdata !== wdata) bus_bad = 1'b1;
      end
      if (rsp_valid) begin
        done = 1'b1;
        got  = sb.pop_front();
        tests++;
        if (rsp_rdata !== got.rdata) begin
          fails++;
          $display("FAIL %s rdata: got %h want %h", name, rsp_rdata, got.rdata);
        end
        tests++;
        if (rsp_err !== got.err) begin
          fails++;
          $display("FAIL %s err: got %b want %b", name, rsp_err, got.err);
        end
        tests++;
        if (n !== got.lat) begin
          fails++;
          $display("FAIL %s latency: got %0d want %0d", name, n, got.lat);
        end
        tests++;
        if (MOV !== 1'b0) begin
          fails++;
          $display("FAIL %s mov_in_done: got %b want 0", name, MOV);
        end
      end else begin
        tick();
        n++;
      end
    end

    if (!done) begin
      void'(sb.pop_front());
      tests++; fails++;
      $display("FAIL %s no_response: rsp_valid never seen within 40 cycles", name);
    end

    tests++;
    if (mov_seen !== (exp_err == ERR_OK || exp_err == ERR_TIMEOUT)) begin
      fails++;
      $display("FAIL %s mov_activity: got %b want %b", name, mov_seen,
               (exp_err == ERR_OK || exp_err == ERR_TIMEOUT));
    end
    tests++;
    if (bus_bad) begin
      fails++;
      $display("FAIL %s bus_stable: Address/mem_wdata differed from %h/%h while MOV=1",
               name, addr, wdata);
    end

    tick();
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s pulse_end: rsp_valid=%b req_ready=%b want 0/1", name, rsp_valid, req_ready);
    end
  endtask

  task automatic check_reset_values(input string name);
    tests++;
    if (MOV !== 1'b0 || RW !== 1'b1 || Address !== 32'h0 || mem_wdata !== 32'h0 || OP !== 6'h0) begin
      fails++;
      $display("FAIL %s mem_outputs: MOV=%b RW=%b Address=%h mem_wdata=%h OP=%b want 0/1/0/0/0",
               name, MOV, RW, Address, mem_wdata, OP);
    end
    tests++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 3'b000 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s rsp_outputs: rsp_valid=%b rsp_rdata=%h rsp_err=%b req_ready=%b want 0/0/000/1",
               name, rsp_valid, rsp_rdata, rsp_err, req_ready);
    end
  endtask

  task automatic test_reset();
    Clr = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    Clr = 1'b1;
    tick();
    check_reset_values("post_reset_idle");
  endtask

  task automatic test_loads();
    ram[16] = 8'hEF; ram[17] = 8'hBE; ram[18] = 8'hAD; ram[19] = 8'hDE;
    ram[33] = 8'h80;
    ram[34] = 8'h01; ram[35] = 8'h80;
    moc_delay = 1;
    send("lw_0x10",  OP_LW,  32'h10, 32'h0, 32'hDEADBEEF, ERR_OK, 3);
    send("lb_0x21",  OP_LB,  32'h21, 32'h0, 32'hFFFFFF80, ERR_OK, 3);
    send("lbu_0x21", OP_LBU, 32'h21, 32'h0, 32'h00000080, ERR_OK, 3);
    send("lh_0x22",  OP_LH,  32'h22, 32'h0, 32'hFFFF8001, ERR_OK, 3);
    send("lhu_0x22", OP_LHU, 32'h22, 32'h0, 32'h00008001, ERR_OK, 3);
    moc_delay = 4;
    send("lw_slow",  OP_LW,  32'h10, 32'h0, 32'hDEADBEEF, ERR_OK, 6);
    moc_delay = 1;
  endtask

  task automatic test_errors();
    send("sh_misaligned",    OP_SH,     32'h21,  32'h0000BEEF, 32'h0, ERR_MISALIGN, 1);
    send("lw_out_of_range",  OP_LW,     32'h200, 32'h0,        32'h0, ERR_RANGE,    1);
    send("illegal_op",       6'b000000, 32'h10,  32'h0,        32'h0, ERR_ILLEGAL,  1);
    send("illegal_priority", 6'b000000, 32'h201, 32'h0,        32'h0, ERR_ILLEGAL,  1);
    send("misalign_prio",    OP_LW,     32'h202, 32'h0,        32'h0, ERR_MISALIGN, 1);
    send("sw_last_word",     OP_SW,     32'h1FC, 32'hCAFEF00D, 32'h0, ERR_OK,       3);
    send("lw_last_word",     OP_LW,     32'h1FC, 32'h0,        32'hCAFEF00D, ERR_OK, 3);
  endtask

  task automatic test_timeout();
    moc_delay = 1000;
    send("lw_timeout", OP_LW, 32'h10, 32'h0, 32'h0, ERR_TIMEOUT, 2 + TIMEOUT);
    moc_delay = 1;
  endtask

  task automatic test_back_to_back();
    moc_delay = 1;
    moc_stale = 1'b1;
    send("b2b_sw", OP_SW, 32'h40, 32'h12345678, 32'h0,        ERR_OK, 3);
    send("b2b_lw", OP_LW, 32'h40, 32'h0,        32'h12345678, ERR_OK, 3);
    moc_stale = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int seen;
    moc_delay = 1000;
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h10; req_wdata = 32'h0;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    tests++;
    if (MOV !== 1'b1) begin
      fails++;
      $display("FAIL mid_wait_mov: got %b want 1 before reset", MOV);
    end
    Clr = 1'b0;
    tick();
    check_reset_values("reset_in_wait");
    Clr = 1'b1;
    seen = 0;
    repeat (25) begin
      tick();
      if (rsp_valid === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL reset_drop: rsp_valid seen %0d times want 0", seen);
    end
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: req_ready=%b want 1", req_ready);
    end
    moc_delay = 1;
    send("after_reset_lw", OP_LW, 32'h10, 32'h0, 32'hDEADBEEF, ERR_OK, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) ram[i] = 8'h00;
    Clr = 1'b0; req_valid = 1'b0; req_op = 6'b0; req_addr = 32'h0; req_wdata = 32'h0;
    MOC = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_loads();
    test_errors();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
